// File: rtl/frame_ring_pkg.sv
// Shared types and helpers for the per-channel frame ring arbiter:
// slot states, slot search and the default feed address map.
package frame_ring_pkg;

    localparam int unsigned MAX_FRAMES = 16;
    localparam int unsigned IDX_W      = 4;

    localparam logic [3*26-1:0] DEF_CH_BASE   = {26'h01F00000, 26'h01E00000, 26'h01000000};
    localparam logic [3*26-1:0] DEF_CH_STRIDE = {26'h0000010, 26'h0000010, 26'h0020000};

    typedef enum logic [1:0] {
        SLOT_FREE,
        SLOT_WRITING,
        SLOT_READY,
        SLOT_READING
    } slot_state_t;

    typedef slot_state_t slot_arr_t [MAX_FRAMES];

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } slot_find_t;

    // Lowest-index slot among the first n that holds state st.
    function automatic slot_find_t find_slot(input slot_arr_t slots,
                                             input int unsigned n,
                                             input slot_state_t st);
        slot_find_t r;
        r.found = 1'b0;
        r.idx   = '0;
        for (int unsigned i = 0; i < MAX_FRAMES; i++) begin
            if (!r.found && (i < n) && (slots[i] == st)) begin
                r.found = 1'b1;
                r.idx   = IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/frame_ring_channel.sv
// One channel of the frame ring: slot states, ordered producer/consumer
// event handling, drop counter, sticky protocol error and base registers.
module frame_ring_channel
    import frame_ring_pkg::*;
#(
    parameter int unsigned NUM_FRAMES = 3,
    parameter int unsigned ADDR_W     = 26,
    parameter int unsigned DROP_W     = 16,
    parameter logic [ADDR_W-1:0] BASE   = '0,
    parameter logic [ADDR_W-1:0] STRIDE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_acquire,
    input  logic              wr_release,
    input  logic              rd_acquire,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_base,
    output logic [ADDR_W-1:0] rd_base,
    output logic              rd_fresh,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              proto_err
);

    if (NUM_FRAMES < 3 || NUM_FRAMES > MAX_FRAMES) begin : g_bad_frames
        $error("frame_ring_channel: NUM_FRAMES must be in 3..MAX_FRAMES");
    end

    slot_arr_t         slot_q, slot_d;
    logic              wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0] wr_base_q, wr_base_d;
    logic [ADDR_W-1:0] rd_base_q, rd_base_d;
    logic              rd_fresh_q, rd_fresh_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              proto_err_q, proto_err_d;

    slot_find_t        wrt_f, old_rdy_f, rdy_f, rding_f, free_f;
    logic              owning;

    function automatic logic [ADDR_W-1:0] slot_addr(input logic [IDX_W-1:0] idx);
        return BASE + ADDR_W'(idx) * STRIDE;
    endfunction

    // Events are applied in order release -> read -> acquire on slot_d,
    // so later events observe the slots earlier events just changed.
    always_comb begin
        slot_d      = slot_q;
        wr_base_d   = wr_base_q;
        rd_base_d   = rd_base_q;
        rd_fresh_d  = rd_fresh_q;
        drop_cnt_d  = drop_cnt_q;
        proto_err_d = proto_err_q;

        wrt_f     = find_slot(slot_q, NUM_FRAMES, SLOT_WRITING);
        old_rdy_f = find_slot(slot_q, NUM_FRAMES, SLOT_READY);
        owning    = wrt_f.found;

        if (wr_release) begin
            if (wrt_f.found) begin
                if (old_rdy_f.found) begin
                    slot_d[old_rdy_f.idx] = SLOT_FREE;
                    if (drop_cnt_q != '1) begin
                        drop_cnt_d = drop_cnt_q + DROP_W'(1);
                    end
                end
                slot_d[wrt_f.idx] = SLOT_READY;
                owning            = 1'b0;
            end else begin
                proto_err_d = 1'b1;
            end
        end

        rdy_f   = find_slot(slot_d, NUM_FRAMES, SLOT_READY);
        rding_f = find_slot(slot_d, NUM_FRAMES, SLOT_READING);

        if (rd_acquire) begin
            if (rdy_f.found && rding_f.found) begin
                slot_d[rding_f.idx] = SLOT_FREE;
                slot_d[rdy_f.idx]   = SLOT_READING;
                rd_base_d           = slot_addr(rdy_f.idx);
                rd_fresh_d          = 1'b1;
            end else begin
                rd_fresh_d = 1'b0;
            end
        end

        free_f = find_slot(slot_d, NUM_FRAMES, SLOT_FREE);

        if (wr_acquire) begin
            if (owning) begin
                proto_err_d = 1'b1;
            end else if (free_f.found) begin
                slot_d[free_f.idx] = SLOT_WRITING;
                wr_base_d          = slot_addr(free_f.idx);
                owning             = 1'b1;
            end
        end

        wr_valid_d = owning;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < MAX_FRAMES; i++) begin
                slot_q[i] <= (i == 0) ? SLOT_READING : SLOT_FREE;
            end
            wr_valid_q  <= 1'b0;
            wr_base_q   <= BASE;
            rd_base_q   <= BASE;
            rd_fresh_q  <= 1'b0;
            drop_cnt_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            wr_valid_q  <= wr_valid_d;
            wr_base_q   <= wr_base_d;
            rd_base_q   <= rd_base_d;
            rd_fresh_q  <= rd_fresh_d;
            drop_cnt_q  <= drop_cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign wr_valid  = wr_valid_q;
    assign wr_base   = wr_base_q;
    assign rd_base   = rd_base_q;
    assign rd_fresh  = rd_fresh_q;
    assign drop_cnt  = drop_cnt_q;
    assign proto_err = proto_err_q;

endmodule

// File: rtl/frame_ring_arbiter.sv
// Per-channel N-frame buffer ownership arbiter between the USB producer and
// cartridge consumer; hands out frame slots and their SDRAM base addresses.
module frame_ring_arbiter
    import frame_ring_pkg::*;
#(
    parameter int unsigned NUM_CH     = 3,
    parameter int unsigned NUM_FRAMES = 3,
    parameter int unsigned ADDR_W     = 26,
    parameter logic [NUM_CH*ADDR_W-1:0] CH_BASE   = DEF_CH_BASE,
    parameter logic [NUM_CH*ADDR_W-1:0] CH_STRIDE = DEF_CH_STRIDE,
    parameter int unsigned DROP_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        wr_acquire,
    input  logic [NUM_CH-1:0]        wr_release,
    input  logic [NUM_CH-1:0]        rd_acquire,
    output logic [NUM_CH-1:0]        wr_valid,
    output logic [NUM_CH*ADDR_W-1:0] wr_base,
    output logic [NUM_CH*ADDR_W-1:0] rd_base,
    output logic [NUM_CH-1:0]        rd_fresh,
    output logic [NUM_CH*DROP_W-1:0] drop_cnt,
    output logic [NUM_CH-1:0]        proto_err
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        frame_ring_channel #(
            .NUM_FRAMES (NUM_FRAMES),
            .ADDR_W     (ADDR_W),
            .DROP_W     (DROP_W),
            .BASE       (CH_BASE[c*ADDR_W +: ADDR_W]),
            .STRIDE     (CH_STRIDE[c*ADDR_W +: ADDR_W])
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .wr_acquire (wr_acquire[c]),
            .wr_release (wr_release[c]),
            .rd_acquire (rd_acquire[c]),
            .wr_valid   (wr_valid[c]),
            .wr_base    (wr_base[c*ADDR_W +: ADDR_W]),
            .rd_base    (rd_base[c*ADDR_W +: ADDR_W]),
            .rd_fresh   (rd_fresh[c]),
            .drop_cnt   (drop_cnt[c*DROP_W +: DROP_W]),
            .proto_err  (proto_err[c])
        );
    end

endmodule
